// File: rtl/microseq_ctrl_pkg.sv
// microaddr: shared types for the microsequencer
//   cmd      - command issued to the microaddress counter
//   seq_op_e - sequencing opcodes carried in the microword
//   state_e  - sequencer FSM states
//   *_LSB    - microword field bit positions
package microaddr;
    typedef enum logic [1:0] {
        CMD_INC   = 2'd0,
        CMD_LOAD  = 2'd1,
        CMD_HOLD  = 2'd2,
        CMD_CLEAR = 2'd3
    } cmd;
    typedef enum logic [3:0] {
        OP_NEXT     = 4'd0,
        OP_JUMP     = 4'd1,
        OP_JCOND    = 4'd2,
        OP_JNCOND   = 4'd3,
        OP_CALL     = 4'd4,
        OP_RET      = 4'd5,
        OP_DISPATCH = 4'd6,
        OP_WAIT     = 4'd7,
        OP_HALT     = 4'd8
    } seq_op_e;
    typedef enum logic [1:0] {ST_INIT, ST_RUN, ST_WAIT, ST_HALT} state_e;
    localparam int SEQ_OP_LSB   = 28;
    localparam int COND_SEL_LSB = 24;
    localparam int TARGET_LSB   = 13;
    localparam int CTRL_LSB     = 0;
endpackage

// File: rtl/microseq_ctrl_stack.sv
// microseq_stack: microsubroutine return-address stack
//   clk, reset   - clock, async active-high reset (empties the stack)
//   push, pop    - push din / pop top; ignored when full / empty
//   din          - return address to push
//   top          - most recently pushed address (0 when empty)
//   full, empty  - occupancy flags
module microseq_stack #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  logic        pop,
    input  logic [10:0] din,
    output logic [10:0] top,
    output logic        full,
    output logic        empty
);
    localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SPW = $clog2(DEPTH + 1);
    logic [10:0]    mem [DEPTH];
    logic [SPW-1:0] sp;
    assign full  = sp == SPW'(DEPTH);
    assign empty = sp == '0;
    assign top   = empty ? '0 : mem[IW'(sp - 1'b1)];
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sp <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (push && !full) begin
            mem[IW'(sp)] <= din;
            sp           <= sp + 1'b1;
        end else if (pop && !empty) begin
            sp <= sp - 1'b1;
        end
    end
endmodule

// File: rtl/microseq_ctrl.sv
// microseq_ctrl: microcode sequencer driving a microaddress counter
//   clk, reset            - clock, async active-high reset
//   uword, cur_addr       - microword at cur_addr, and cur_addr itself
//   cond_flags, opcode    - branch conditions, dispatch opcode
//   mem_busy              - memory in flight (only looked at by WAIT)
//   cmd, load_addr        - counter command and load target
//   ctrl_out              - datapath control field
//   stall, halted         - waiting on memory, stopped until reset
//   stack_err             - sticky return-stack fault
// Build option MICROSEQ_STACK_EN: enables the CALL/RET return stack;
// without it CALL is a plain JUMP and RET faults into HALT.
module microseq_ctrl
    import microaddr::*;
#(
    parameter int STACK_DEPTH = 4,
    parameter int UWORD_W     = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [UWORD_W-1:0] uword,
    input  logic [10:0]        cur_addr,
    input  logic [15:0]        cond_flags,
    input  logic [7:0]         opcode,
    input  logic               mem_busy,
    output microaddr::cmd      cmd,
    output logic [10:0]        load_addr,
    output logic [12:0]        ctrl_out,
    output logic               stall,
    output logic               halted,
    output logic               stack_err
);
    logic [3:0]  seq_op;
    logic [3:0]  cond_sel;
    logic [10:0] target;
    logic [12:0] ctrl;
    logic        cond;
    logic        err_set;
    state_e      state, state_nxt;
    assign seq_op   = uword[SEQ_OP_LSB +: 4];
    assign cond_sel = uword[COND_SEL_LSB +: 4];
    assign target   = uword[TARGET_LSB +: 11];
    assign ctrl     = uword[CTRL_LSB +: 13];
    assign cond     = cond_flags[cond_sel];
`ifdef MICROSEQ_STACK_EN
    logic        push, pop, full, empty;
    logic [10:0] top;
    microseq_stack #(.DEPTH(STACK_DEPTH)) u_stack (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (cur_addr + 11'd1),
        .top   (top),
        .full  (full),
        .empty (empty)
    );
`else
    logic unused_cfg;
    assign unused_cfg = ^{cur_addr, 4'(STACK_DEPTH)};
`endif
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_INIT;
            stack_err <= 1'b0;
        end else begin
            state <= state_nxt;
            if (err_set) stack_err <= 1'b1;
        end
    end
    always_comb begin
        cmd       = CMD_HOLD;
        load_addr = '0;
        ctrl_out  = '0;
        stall     = 1'b0;
        halted    = 1'b0;
        err_set   = 1'b0;
        state_nxt = state;
`ifdef MICROSEQ_STACK_EN
        push = 1'b0;
        pop  = 1'b0;
`endif
        case (state)
            ST_INIT: begin
                cmd       = CMD_CLEAR;
                state_nxt = ST_RUN;
            end
            ST_RUN: begin
                ctrl_out  = ctrl;
                load_addr = target;
                case (seq_op)
                    OP_NEXT:     cmd = CMD_INC;
                    OP_JUMP:     cmd = CMD_LOAD;
                    OP_JCOND:    cmd = cond ? CMD_LOAD : CMD_INC;
                    OP_JNCOND:   cmd = cond ? CMD_INC : CMD_LOAD;
`ifdef MICROSEQ_STACK_EN
                    OP_CALL: begin
                        cmd     = full ? CMD_HOLD : CMD_LOAD;
                        push    = !full;
                        err_set = full;
                    end
                    OP_RET: begin
                        cmd       = empty ? CMD_HOLD : CMD_LOAD;
                        load_addr = top;
                        pop       = !empty;
                        err_set   = empty;
                    end
`else
                    OP_CALL:     cmd = CMD_LOAD;
                    OP_RET:      err_set = 1'b1;
`endif
                    OP_DISPATCH: begin
                        cmd       = CMD_LOAD;
                        load_addr = {target[10:8], opcode};
                    end
                    OP_WAIT: begin
                        cmd       = mem_busy ? CMD_HOLD : CMD_INC;
                        stall     = mem_busy;
                        state_nxt = mem_busy ? ST_WAIT : ST_RUN;
                    end
                    default: state_nxt = ST_HALT;
                endcase
                // Halting ops and stack faults present an idle datapath
                if (err_set || seq_op >= OP_HALT) begin
                    ctrl_out  = '0;
                    state_nxt = ST_HALT;
                end
            end
            ST_WAIT: begin
                cmd       = mem_busy ? CMD_HOLD : CMD_INC;
                stall     = mem_busy;
                state_nxt = mem_busy ? ST_WAIT : ST_RUN;
            end
            default: halted = 1'b1;
        endcase
    end
endmodule

// File: tb/tb_microseq_ctrl.sv
// tb_microseq_ctrl: directed + randomized check of microseq_ctrl against a queue-based model
module tb_microseq_ctrl;
    import microaddr::*;
    localparam int DEPTH = 4;
`ifdef MICROSEQ_STACK_EN
    localparam bit STACK_EN = 1'b1;
`else
    localparam bit STACK_EN = 1'b0;
`endif
    localparam int M_INIT = 0, M_RUN = 1, M_WAIT = 2, M_HALT = 3;
    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [31:0]   uword = '0;
    logic [10:0]   cur_addr = '0;
    logic [15:0]   cond_flags = '0;
    logic [7:0]    opcode = '0;
    logic          mem_busy = 1'b0;
    microaddr::cmd cmd_o;
    logic [10:0]   load_addr;
    logic [12:0]   ctrl_out;
    logic          stall, halted, stack_err;
    int            checks = 0;
    int            errors = 0;
    int            mode = M_INIT;
    logic [10:0]   q[$];
    bit            m_err = 1'b0;

    microseq_ctrl #(.STACK_DEPTH(DEPTH), .UWORD_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .uword      (uword),
        .cur_addr   (cur_addr),
        .cond_flags (cond_flags),
        .opcode     (opcode),
        .mem_busy   (mem_busy),
        .cmd        (cmd_o),
        .load_addr  (load_addr),
        .ctrl_out   (ctrl_out),
        .stall      (stall),
        .halted     (halted),
        .stack_err  (stack_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [3:0] op, input logic [3:0] cs,
                                       input logic [10:0] tgt, input logic [12:0] ctl);
        return {op, cs, tgt, ctl};
    endfunction

    // Assert reset away from the clock edge, check the async reset outputs, release after an edge
    task automatic do_reset();
        #1 reset = 1'b1;
        #1;
        chk("rst_cmd", 32'(cmd_o), 32'(CMD_CLEAR));
        chk("rst_load_addr", 32'(load_addr), 0);
        chk("rst_ctrl", 32'(ctrl_out), 0);
        chk("rst_stall", 32'(stall), 0);
        chk("rst_halted", 32'(halted), 0);
        chk("rst_stack_err", 32'(stack_err), 0);
        @(posedge clk);
        #1 reset = 1'b0;
        mode  = M_INIT;
        m_err = 1'b0;
        q.delete();
    endtask

    // One clock cycle: apply inputs, predict, compare mid-cycle, then advance the model
    task automatic step(input logic [31:0] uw, input logic [10:0] addr, input logic [15:0] fl,
                        input logic [7:0] opc, input logic busy);
        logic [3:0]    op;
        logic [10:0]   tgt;
        logic [12:0]   ctl;
        logic          cnd;
        microaddr::cmd e_cmd;
        logic [10:0]   e_la;
        logic [12:0]   e_ctrl;
        bit            e_stall, e_halt, go_err, do_push, do_pop;
        int            nmode;
        uword = uw; cur_addr = addr; cond_flags = fl; opcode = opc; mem_busy = busy;
        op  = uw[31:28];
        cnd = fl[uw[27:24]];
        tgt = uw[23:13];
        ctl = uw[12:0];
        e_cmd = CMD_HOLD; e_la = '0; e_ctrl = '0; e_stall = 0; e_halt = 0;
        go_err = 0; do_push = 0; do_pop = 0; nmode = mode;
        case (mode)
            M_INIT: begin e_cmd = CMD_CLEAR; nmode = M_RUN; end
            M_WAIT: if (!busy) begin e_cmd = CMD_INC; nmode = M_RUN; end else e_stall = 1;
            M_HALT: e_halt = 1;
            default: begin
                e_ctrl = ctl;
                case (op)
                    4'd0: e_cmd = CMD_INC;
                    4'd1: begin e_cmd = CMD_LOAD; e_la = tgt; end
                    4'd2: begin e_cmd = cnd ? CMD_LOAD : CMD_INC; e_la = tgt; end
                    4'd3: begin e_cmd = cnd ? CMD_INC : CMD_LOAD; e_la = tgt; end
                    4'd4: if (STACK_EN && q.size() == DEPTH) go_err = 1;
                          else begin e_cmd = CMD_LOAD; e_la = tgt; do_push = STACK_EN; end
                    4'd5: if (!STACK_EN || q.size() == 0) go_err = 1;
                          else begin e_cmd = CMD_LOAD; e_la = q[$]; do_pop = 1; end
                    4'd6: begin e_cmd = CMD_LOAD; e_la = {tgt[10:8], opc}; end
                    4'd7: if (busy) begin e_stall = 1; nmode = M_WAIT; end else e_cmd = CMD_INC;
                    default: begin e_ctrl = '0; nmode = M_HALT; end
                endcase
                if (go_err) begin e_ctrl = '0; nmode = M_HALT; end
            end
        endcase
        #3;
        chk("cmd", 32'(cmd_o), 32'(e_cmd));
        if (e_cmd == CMD_LOAD || e_cmd == CMD_CLEAR) chk("load_addr", 32'(load_addr), 32'(e_la));
        chk("ctrl_out", 32'(ctrl_out), 32'(e_ctrl));
        chk("stall", 32'(stall), 32'(e_stall));
        chk("halted", 32'(halted), 32'(e_halt));
        chk("stack_err", 32'(stack_err), 32'(m_err));
        @(posedge clk);
        #1;
        if (go_err) m_err = 1'b1;
        if (do_push) q.push_back(addr + 11'd1);
        if (do_pop) void'(q.pop_back());
        mode = nmode;
    endtask

    initial begin
        logic [3:0] rop;
        do_reset();
        step(mk(4'd0, 4'd0, 11'h0, 13'h1ABC), 11'h000, 16'h0, 8'h0, 1'b0);
        step(mk(4'd0, 4'd0, 11'h0, 13'h1ABC), 11'h000, 16'h0, 8'h0, 1'b1);
        step(mk(4'd2, 4'd3, 11'h120, 13'h0055), 11'h001, 16'h0008, 8'h0, 1'b0);
        step(mk(4'd2, 4'd3, 11'h120, 13'h0055), 11'h120, 16'hFFF7, 8'h0, 1'b0);
        step(mk(4'd3, 4'd3, 11'h230, 13'h0AAA), 11'h121, 16'h0000, 8'h0, 1'b0);
        step(mk(4'd3, 4'd3, 11'h230, 13'h0AAA), 11'h230, 16'h0008, 8'h0, 1'b0);
        step(mk(4'd1, 4'd0, 11'h7FE, 13'h1FFF), 11'h231, 16'h0, 8'h0, 1'b1);
        step(mk(4'd4, 4'd0, 11'h200, 13'h0123), 11'h7FF, 16'h0, 8'h0, 1'b0);
        step(mk(4'd5, 4'd0, 11'h0, 13'h0321), 11'h200, 16'h0, 8'h0, 1'b0);
        step(mk(4'd0, 4'd0, 11'h0, 13'h0001), 11'h000, 16'h0, 8'h0, 1'b0);
        do_reset();
        step(mk(4'd0, 4'd0, 11'h0, 13'h0), 11'h0, 16'h0, 8'h0, 1'b0);
        for (int i = 0; i < 5; i++)
            step(mk(4'd4, 4'd0, 11'(11'h100 + i), 13'(i + 1)), 11'(11'h010 * i), 16'h0, 8'h0, 1'b0);
        step(mk(4'd0, 4'd0, 11'h0, 13'h0777), 11'h0, 16'h0, 8'h0, 1'b1);
        do_reset();
        step(mk(4'd0, 4'd0, 11'h0, 13'h0), 11'h0, 16'h0, 8'h0, 1'b0);
        step(mk(4'd7, 4'd0, 11'h0, 13'h0F0F), 11'h010, 16'h0, 8'h0, 1'b1);
        step(mk(4'd7, 4'd0, 11'h0, 13'h0F0F), 11'h010, 16'h0, 8'h0, 1'b1);
        step(mk(4'd7, 4'd0, 11'h0, 13'h0F0F), 11'h010, 16'h0, 8'h0, 1'b1);
        step(mk(4'd7, 4'd0, 11'h0, 13'h0F0F), 11'h010, 16'h0, 8'h0, 1'b0);
        step(mk(4'd7, 4'd0, 11'h0, 13'h0333), 11'h011, 16'h0, 8'h0, 1'b0);
        step(mk(4'd6, 4'd0, 11'h500, 13'h0444), 11'h012, 16'h0, 8'h3C, 1'b1);
        step(mk(4'd12, 4'd0, 11'h0, 13'h1555), 11'h53C, 16'h0, 8'h0, 1'b0);
        step(mk(4'd0, 4'd0, 11'h0, 13'h1555), 11'h53C, 16'h0, 8'h0, 1'b1);
        step(mk(4'd1, 4'd0, 11'h0, 13'h1555), 11'h53C, 16'h0, 8'h0, 1'b0);
        do_reset();
        step(mk(4'd0, 4'd0, 11'h0, 13'h0), 11'h0, 16'h0, 8'h0, 1'b0);
        step(mk(4'd4, 4'd0, 11'h300, 13'h0), 11'h040, 16'h0, 8'h0, 1'b0);
        step(mk(4'd7, 4'd0, 11'h0, 13'h0), 11'h300, 16'h0, 8'h0, 1'b1);
        step(mk(4'd7, 4'd0, 11'h0, 13'h0), 11'h300, 16'h0, 8'h0, 1'b1);
        do_reset();
        step(mk(4'd0, 4'd0, 11'h0, 13'h0), 11'h0, 16'h0, 8'h0, 1'b0);
        step(mk(4'd5, 4'd0, 11'h0, 13'h0), 11'h001, 16'h0, 8'h0, 1'b0);
        step(mk(4'd0, 4'd0, 11'h0, 13'h0), 11'h001, 16'h0, 8'h0, 1'b0);
        for (int i = 0; i < 600; i++) begin
            if (mode == M_HALT && $urandom_range(0, 2) == 0) begin
                do_reset();
            end else begin
                rop = ($urandom_range(0, 31) < 29) ? 4'($urandom_range(0, 7)) : 4'($urandom_range(8, 15));
                step(mk(rop, 4'($urandom), 11'($urandom), 13'($urandom)), 11'($urandom),
                     16'($urandom), 8'($urandom), 1'($urandom));
            end
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/microseq_ctrl.md
MICROSEQ_CTRL -- requirements
Module: microseq_ctrl

Interface
REQ-001 Parameters SHALL be: STACK_DEPTH, 4, microsubroutine return-stack entries (2..8); UWORD_W, 32, microword width.
REQ-002 Ports SHALL be: clk  in  1  clock; reset  in  1  reset, asynchronous, active-high.
REQ-003 Ports SHALL be: uword  in  UWORD_W  microword fetched at cur_addr; cur_addr  in  11  microaddress counter output.
REQ-004 Ports SHALL be: cond_flags  in  16  datapath condition flags; opcode  in  8  decoded Z-machine opcode for dispatch; mem_busy  in  1  memory access in flight.
REQ-005 Ports SHALL be: cmd  out  microaddr::cmd  command to the microaddress counter; load_addr  out  11  counter load target.
REQ-006 Ports SHALL be: ctrl_out  out  13  datapath control field; stall  out  1  sequencer waiting; halted  out  1  HALT state; stack_err  out  1  sticky stack fault.

Function
REQ-007 Microword fields SHALL be [31:28] seq_op, [27:24] cond_sel, [23:13] target, [12:0] ctrl.
REQ-008 cond SHALL be cond_flags[cond_sel].
REQ-009 FSM states SHALL be INIT, RUN, WAIT, HALT; cmd, load_addr, ctrl_out combinational from state, uword, stack top.
REQ-010 INIT SHALL last exactly one cycle after reset release, drive cmd=CMD_CLEAR, ctrl_out=0, then go to RUN.
REQ-011 In RUN, seq_op SHALL decode: 0 NEXT -> CMD_INC; 1 JUMP -> CMD_LOAD, load_addr=target; 2 JCOND -> CMD_LOAD if cond else CMD_INC; 3 JNCOND -> CMD_LOAD if !cond else CMD_INC.
REQ-012 seq_op 4 CALL SHALL drive CMD_LOAD to target and push cur_addr+1 (mod 2048) at the clock edge.
REQ-013 seq_op 5 RET SHALL drive CMD_LOAD with load_addr = stack top and pop at the clock edge.
REQ-014 seq_op 6 DISPATCH SHALL drive CMD_LOAD with load_addr={target[10:8], opcode}.
REQ-015 seq_op 7 WAIT SHALL drive CMD_HOLD, stall=1, and enter WAIT if mem_busy=1; if mem_busy=0, it SHALL behave as NEXT.
REQ-016 In WAIT, cmd SHALL be CMD_HOLD, stall=1, ctrl_out=0; on first cycle mem_busy=0, stall SHALL drop, cmd=CMD_INC, and the state SHALL return to RUN.
REQ-017 seq_op 8 HALT and seq_op 9..15 SHALL enter HALT; HALT SHALL drive CMD_HOLD, ctrl_out=0, halted=1 until reset.
REQ-018 CALL with stack full (overflow) or RET with stack empty (underflow) SHALL set stack_err, drive CMD_HOLD, leave the stack unchanged, and enter HALT.
REQ-019 In RUN with a non-halting op, ctrl_out SHALL equal the uword ctrl field.
REQ-020 mem_busy SHALL be ignored outside seq_op WAIT and state WAIT.

Reset
REQ-021 Reset assertion SHALL asynchronously force state INIT, stack pointer 0, and stack_err=0.
REQ-022 During reset, outputs SHALL be cmd=CMD_CLEAR, load_addr=0, ctrl_out=0, stall=0, halted=0.
REQ-023 Reset mid-WAIT or mid-HALT SHALL discard all state, including stack contents.

Configuration
REQ-024 With MICROSEQ_STACK_EN defined, CALL/RET SHALL behave per REQ-012/013/018.
REQ-025 Without MICROSEQ_STACK_EN, no stack storage SHALL exist, CALL SHALL act as JUMP, RET SHALL enter HALT with stack_err=1, and STACK_DEPTH SHALL be unused.

Structure
REQ-026 Package microaddr SHALL hold typedef cmd (CMD_INC, CMD_LOAD, CMD_HOLD, CMD_CLEAR), the seq_op enum, and microword field bit-position constants.
REQ-027 The return stack SHALL be sub-module microseq_stack (push, pop, top, full, empty), instantiated only under MICROSEQ_STACK_EN.

Verification
REQ-028 Reset release -> one cycle cmd=CMD_CLEAR, then NEXT microword gives cmd=CMD_INC, ctrl_out=uword[12:0].
REQ-029 JCOND cond_sel=3, target=0x120, cond_flags[3]=1 -> CMD_LOAD, load_addr=0x120; with cond_flags[3]=0 -> CMD_INC.
REQ-030 CALL target=0x200 at cur_addr=0x7FF, then RET -> load_addr=0x000 (wrap); five nested CALLs with STACK_DEPTH=4 -> fifth sets stack_err=1, halted=1.
REQ-031 WAIT with mem_busy high for 3 cycles -> stall=1 and CMD_HOLD for 3 cycles, then CMD_INC with stall=0.
REQ-032 DISPATCH target=0x500, opcode=0x3C -> load_addr=0x53C; seq_op=12 -> HALT, then reset asserted mid-HALT -> INIT and stack_err=0.
